control_cmd_serializer: RTL and testbench

//  Host-side transmitter for the control byte protocol. Takes one parallel command (opcode + block/reg/data/instr

---
 rtl/control_cmd_serializer.sv | 182 ++++++++++++++++++
 tb/tb_control_cmd_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_serializer.sv
// Frames one parallel control command into the control-unit byte stream with a valid/next handshake.
// Optional byte-ack timeout enabled by defining CMD_TX_TIMEOUT_EN.
`ifndef BLOCK_REG_ADDR_WIDTH
`define BLOCK_REG_ADDR_WIDTH 8
`endif
`ifndef BLOCK_INSTR_WIDTH
`define BLOCK_INSTR_WIDTH 32
`endif
`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR 8'h01
`define COMMAND_WRITE_BLOCK_REG   8'h02
`define COMMAND_UPDATE_BLOCK_REG  8'h03
`define COMMAND_ALLOC_SRAM_DELAY  8'h04
`define COMMAND_SWAP_PIPELINES    8'h05
`define COMMAND_RESET_PIPELINE    8'h0D
`endif

module control_cmd_serializer #(
  parameter int n_blocks       = 32,
  parameter int data_width     = 16,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [7:0]                       cmd_opcode,
  input  logic [$clog2(n_blocks)-1:0]      cmd_block,
  input  logic [`BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg,
  input  logic [data_width-1:0]            cmd_data,
  input  logic [`BLOCK_INSTR_WIDTH-1:0]    cmd_instr,
  output logic [7:0]                       out_byte,
  output logic                             out_valid,
  input  logic                             next,
  output logic                             cmd_done,
  output logic                             cmd_error,
  output logic                             cmd_timeout
);
  localparam int BW   = $clog2(n_blocks);
  localparam int RW   = `BLOCK_REG_ADDR_WIDTH;
  localparam int IW   = `BLOCK_INSTR_WIDTH;
  localparam int DB   = data_width / 8;
  localparam int IB   = IW / 8;
  localparam int MAXB = 2 + ((IB > DB + 1) ? IB : DB + 1);
  localparam int FW   = 8 * MAXB;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int GW   = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE, ERR} state_t;

  state_t          state;
  logic [FW-1:0]   frame_q, frame_c;
  logic [CW-1:0]   left, nbytes_c;
  logic [GW-1:0]   gcnt;
  logic            op_ok;
  logic [7:0]      b8, r8;

  // Frame is left-aligned: the byte to send next always sits in the top 8 bits.
  always_comb begin
    frame_c  = '0;
    nbytes_c = '0;
    op_ok    = 1'b1;
    b8       = '0;
    r8       = '0;
    b8[BW-1:0] = cmd_block;
    r8[RW-1:0] = cmd_reg;
    frame_c[FW-1 -: 8] = cmd_opcode;
    case (cmd_opcode)
      `COMMAND_WRITE_BLOCK_INSTR: begin
        frame_c[FW-9 -: 8]   = b8;
        frame_c[FW-17 -: IW] = cmd_instr;
        nbytes_c = CW'(2 + IB);
      end
      `COMMAND_WRITE_BLOCK_REG, `COMMAND_UPDATE_BLOCK_REG: begin
        frame_c[FW-9 -: 8]           = b8;
        frame_c[FW-17 -: 8]          = r8;
        frame_c[FW-25 -: data_width] = cmd_data;
        nbytes_c = CW'(3 + DB);
      end
      `COMMAND_ALLOC_SRAM_DELAY: begin
        frame_c[FW-9 -: data_width] = cmd_data;
        nbytes_c = CW'(1 + DB);
      end
      `COMMAND_SWAP_PIPELINES, `COMMAND_RESET_PIPELINE: nbytes_c = CW'(1);
      default: op_ok = 1'b0;
    endcase
  end

`ifdef CMD_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  assign cmd_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      out_byte  <= '0;
      out_valid <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      frame_q   <= '0;
      left      <= '0;
      gcnt      <= '0;
`ifdef CMD_TX_TIMEOUT_EN
      cmd_timeout <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
`ifdef CMD_TX_TIMEOUT_EN
      cmd_timeout <= 1'b0;
`endif
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          if (op_ok) begin
            frame_q <= frame_c;
            left    <= nbytes_c;
            state   <= LOAD;
          end else begin
            cmd_error <= 1'b1;
            state     <= ERR;
          end
        end
        LOAD: begin
          out_byte  <= frame_q[FW-1 -: 8];
          out_valid <= 1'b1;
          state     <= SEND;
`ifdef CMD_TX_TIMEOUT_EN
          tcnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        SEND: if (next) begin
          out_valid <= 1'b0;
          if (left == CW'(1)) begin
            cmd_done <= 1'b1;
            state    <= DONE;
          end else begin
            out_byte <= frame_q[FW-9 -: 8];
            frame_q  <= frame_q << 8;
            left     <= left - CW'(1);
            gcnt     <= GW'(GAP_CYCLES - 1);
            state    <= GAP;
          end
        end
`ifdef CMD_TX_TIMEOUT_EN
        else if (tcnt == '0) begin
          out_valid   <= 1'b0;
          cmd_timeout <= 1'b1;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end else begin
          tcnt <= tcnt - TW'(1);
        end
`endif
        GAP: if (gcnt == '0) begin
          out_valid <= 1'b1;
          state     <= SEND;
`ifdef CMD_TX_TIMEOUT_EN
          tcnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end else begin
          gcnt <= gcnt - GW'(1);
        end
        DONE, ERR: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_cmd_serializer.sv
// Table-driven bench for control_cmd_serializer: expected bytes are queued at drive time and
// popped by a sink process that also acts as the control_unit consumer.
`ifndef COMMAND_WRITE_BLOCK_INSTR
`define COMMAND_WRITE_BLOCK_INSTR 8'h01
`define COMMAND_WRITE_BLOCK_REG   8'h02
`define COMMAND_UPDATE_BLOCK_REG  8'h03
`define COMMAND_ALLOC_SRAM_DELAY  8'h04
`define COMMAND_SWAP_PIPELINES    8'h05
`define COMMAND_RESET_PIPELINE    8'h0D
`endif

module tb_control_cmd_serializer;
  localparam int GAP = 1;
`ifdef CMD_TX_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic        clk, reset_n, cmd_valid, cmd_ready, out_valid, next;
  logic        cmd_done, cmd_error, cmd_timeout;
  logic [7:0]  cmd_opcode, cmd_reg, out_byte;
  logic [4:0]  cmd_block;
  logic [15:0] cmd_data;
  logic [31:0] cmd_instr;

  control_cmd_serializer #(.n_blocks(32), .data_width(16), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_block(cmd_block), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .cmd_instr(cmd_instr), .out_byte(out_byte), .out_valid(out_valid), .next(next),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_timeout(cmd_timeout));

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  blk;
    logic [7:0]  rg;
    logic [15:0] data;
    logic [31:0] instr;
    int          delay;
    bit          err;
    int          n;
    logic [47:0] bytes;
  } vec_t;

  vec_t       tv [8];
  logic [7:0] q [$];
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, to_cnt = 0, pos = 0, cur_delay = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation still running, required finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Consumer: checks each new byte against the scoreboard, then pulses next after cur_delay cycles.
  initial begin : sink
    bit         seen;
    int         hold, low_run;
    logic [7:0] cur_b, exp_b;
    seen = 0; hold = 0; low_run = 0; cur_b = '0;
    next = 1'b0;
    forever begin
      @(negedge clk);
      next = 1'b0;
      if (cmd_done)    done_cnt++;
      if (cmd_error)   err_cnt++;
      if (cmd_timeout) to_cnt++;
      if (!reset_n) begin
        seen = 0; low_run = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1; hold = cur_delay; cur_b = out_byte;
          if (pos > 0) check("gap_cycles", low_run, GAP);
          check("byte_expected", q.size() != 0, 1);
          if (q.size() != 0) begin
            exp_b = q.pop_front();
            check("byte_value", out_byte, exp_b);
          end
          pos++;
        end else begin
          check("byte_stable", out_byte, cur_b);
        end
        low_run = 0;
        if (hold == 0) begin
          next = 1'b1; seen = 0;
        end else hold--;
      end else begin
        seen = 0; low_run++;
      end
    end
  end

  task automatic start_cmd(input vec_t v);
    check("ready_before_cmd", cmd_ready, 1);
    for (int i = 0; i < v.n; i++) q.push_back(v.bytes[47-8*i -: 8]);
    pos = 0;
    cur_delay = v.delay;
    cmd_opcode = v.op; cmd_block = v.blk; cmd_reg = v.rg; cmd_data = v.data; cmd_instr = v.instr;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("ready_low_after_accept", cmd_ready, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, waited;
    logic prev_done, ready_follow;
    d0 = done_cnt; e0 = err_cnt;
    start_cmd(v);
    waited = 1; prev_done = cmd_done; ready_follow = 1'b0;
    while (cmd_ready !== 1'b1 && waited < 300) begin
      tick();
      waited++;
      if (cmd_ready === 1'b1) ready_follow = prev_done;
      else prev_done = cmd_done;
    end
    check("frame_finished", cmd_ready, 1);
    if (v.err) check("error_ready_cycles", waited, 2);
    else       check("ready_after_done", ready_follow, 1);
    check("byte_count", pos, v.n);
    check("queue_drained", q.size(), 0);
    check("done_pulses", done_cnt - d0, v.err ? 0 : 1);
    check("error_pulses", err_cnt - e0, v.err ? 1 : 0);
  endtask

  initial begin : main
    int d0, cnt;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_block = '0;
    cmd_reg = '0; cmd_data = '0; cmd_instr = '0;

    tv[0] = '{`COMMAND_WRITE_BLOCK_REG,   5'd5,  8'h03, 16'hBEEF, 32'h0,        3, 0, 5, 48'h02_05_03_BE_EF_00};
    tv[1] = '{`COMMAND_WRITE_BLOCK_INSTR, 5'd2,  8'h77, 16'h9999, 32'h12345678, 1, 0, 6, 48'h01_02_12_34_56_78};
    tv[2] = '{`COMMAND_UPDATE_BLOCK_REG,  5'd31, 8'hA5, 16'h0001, 32'hFFFFFFFF, 0, 0, 5, 48'h03_1F_A5_00_01_00};
    tv[3] = '{`COMMAND_ALLOC_SRAM_DELAY,  5'd7,  8'h55, 16'h1234, 32'hDEADBEEF, 2, 0, 3, 48'h04_12_34_00_00_00};
    tv[4] = '{`COMMAND_SWAP_PIPELINES,    5'd9,  8'h11, 16'hAAAA, 32'h1,        0, 0, 1, 48'h05_00_00_00_00_00};
    tv[5] = '{`COMMAND_RESET_PIPELINE,    5'd3,  8'h22, 16'h5555, 32'h2,        0, 0, 1, 48'h0D_00_00_00_00_00};
    tv[6] = '{8'hFF,                      5'd1,  8'h01, 16'h0101, 32'h3,        0, 1, 0, 48'h0};
    tv[7] = '{8'h09,                      5'd4,  8'h02, 16'h0202, 32'h4,        0, 1, 0, 48'h0};

    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_cmd_timeout", cmd_timeout, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Reset while the third byte of a WRITE_BLOCK_REG frame is pending.
    tv[0].delay = 50;
    d0 = done_cnt;
    start_cmd(tv[0]);
    cnt = 0;
    while (!(pos == 3 && out_valid) && cnt < 300) begin
      tick(); cnt++;
    end
    check("reached_third_byte", pos, 3);
    reset_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    q.delete();
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_idle_valid", out_valid, 0);
    run_vec(tv[3]);

`ifdef CMD_TX_TIMEOUT_EN
    d0 = done_cnt;
    tv[4].delay = 100000;
    start_cmd(tv[4]);
    cnt = 0;
    for (int i = 0; i < 100 && !cmd_timeout; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("timeout_pulse", cmd_timeout, 1);
    check("timeout_send_cycles", cnt, TO);
    check("timeout_valid_low", out_valid, 0);
    check("timeout_ready", cmd_ready, 1);
    tick();
    check("timeout_single_pulse", cmd_timeout, 0);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_count", to_cnt, 1);
    tv[4].delay = 0;
    run_vec(tv[4]);
`else
    check("timeout_never", to_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
